or_tree_pipe: RTL
=================

OR_TREE_PIPE -- requirements
Module: or_tree_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: inputs OR-reduced per lane; legal range 2..64.
REQ-002 SHALL have parameter LANES, default 4: independent reduction channels; legal range 1..16.
REQ-003 SHALL have parameter LEVELS_PER_STAGE, default 2: number of 2-input OR tree levels between pipeline registers; legal range 1..6.
REQ-004 SHALL have port CLK, input, 1 bit: single clock, rising edge active.
REQ-005 SHALL have port R, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port A, input, LANES*WIDTH bits: lane k occupies bits [k*WIDTH +: WIDTH].
REQ-007 SHALL have port VALID_IN, input, 1 bit: A is valid this cycle.
REQ-008 SHALL have port READY_OUT, output, 1 bit: block accepts A this cycle.
REQ-009 SHALL have port Y, output, LANES bits: bit k is the OR of lane k.
REQ-010 SHALL have port VALID_OUT, output, 1 bit: Y is valid.
REQ-011 SHALL have port READY_IN, input, 1 bit: downstream accepts Y.
REQ-012 SHALL have port CLR, input, 1 bit, present only when OR_TREE_STICKY_EN is defined: synchronous sticky clear.
REQ-013 SHALL have port STICKY, output, LANES bits, present only when OR_TREE_STICKY_EN is defined: accumulated OR.

Function
REQ-014 SHALL use D = ceil(log2 WIDTH) tree levels and S = max(1, ceil(D/LEVELS_PER_STAGE)) register stages; the final stage drives Y and VALID_OUT.
REQ-015 SHALL pad unused tree leaves with 0 when WIDTH is not a power of two.
REQ-016 SHALL accept a beat when VALID_IN && READY_OUT.
REQ-017 SHALL transfer a beat out when VALID_OUT && READY_IN.
REQ-018 SHALL give each stage i a valid bit v[i]; stage i loads when !v[i] || rdy[i+1], where rdy[S] = READY_IN and rdy[i] = !v[i] || rdy[i+1].
REQ-019 SHALL drive READY_OUT = rdy[0], combinationally from READY_IN; no other combinational input-to-output path is allowed.
REQ-020 SHALL, when a stage loads with no valid upstream data, clear its valid bit; data bits then hold their previous values.
REQ-021 SHALL have a latency of exactly S cycles from acceptance to VALID_OUT when there is no backpressure.
REQ-022 SHALL sustain a throughput of 1 beat per cycle while READY_IN = 1.
REQ-023 SHALL hold Y and VALID_OUT stable while VALID_OUT && !READY_IN, with no beat lost or duplicated.
REQ-024 SHALL, with the pipeline full and READY_IN = 0, hold READY_OUT = 0 and ignore A.
REQ-025 SHALL, on a simultaneous full-pipeline condition and READY_IN rising, accept a new beat in the same cycle (READY_OUT = 1).
REQ-026 SHALL keep the lanes fully independent, sharing only the valid/ready control.

Reset
REQ-027 SHALL, while R = 0, asynchronously clear all v[i], VALID_OUT, Y and STICKY to 0.
REQ-028 SHALL discard in-flight beats on a reset asserted mid-operation; no output appears after release.
REQ-029 SHALL drive READY_OUT = 1 during and after reset.

Configuration
REQ-030 SHALL, when macro OR_TREE_STICKY_EN is defined, compile in CLR and STICKY.
REQ-031 SHALL update STICKY on each output transfer as STICKY |= Y.
REQ-032 SHALL have CLR set STICKY to 0.
REQ-033 SHALL, when CLR coincides with a transfer, set STICKY to the transferred Y, so the clear precedes the accumulate.
REQ-034 SHALL, when OR_TREE_STICKY_EN is undefined, omit the CLR and STICKY ports and logic; all other behaviour is identical.

Verification
REQ-035 SHALL cover: defaults, READY_IN = 1, A = 0x80_00_01_00 for one beat -> Y = 4'b1010, VALID_OUT high exactly 2 cycles after acceptance, for one cycle.
REQ-036 SHALL cover: back-to-back 16 random beats with READY_IN = 1 -> 16 consecutive VALID_OUT cycles, each Y matching a reference OR model in order.
REQ-037 SHALL cover: READY_IN = 0 for 5 cycles while VALID_IN = 1 -> READY_OUT falls after 2 beats are accepted; Y holds; on release both beats emerge in order and none is dropped.
REQ-038 SHALL cover: WIDTH = 5, LEVELS_PER_STAGE = 1, lane A = 5'b10000 -> Y = 1 after latency 3.
REQ-039 SHALL cover: R pulsed low with 2 beats in flight -> VALID_OUT = 0, Y = 0, and no beat emerges after release.
REQ-040 SHALL cover, with OR_TREE_STICKY_EN defined: beats with Y = 0001, then 0100 -> STICKY = 0101; CLR together with a beat of Y = 0010 -> STICKY = 0010.

Source files
------------

// File: rtl/or_tree_pipe.sv
// Pipelined per-lane OR-reduction tree with valid/ready flow control.
// Optional sticky accumulator compiled in with OR_TREE_STICKY_EN (adds CLR and STICKY).

module or_tree_lane #(
    parameter int WIDTH = 8,
    parameter int LPS   = 2,
    parameter int D     = 3,
    parameter int S     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [S-1:0]     en,
    output logic             y
);
    localparam int P = 1 << D;

    function automatic logic [P-1:0] or_level(input logic [P-1:0] x);
        logic [P-1:0] r;
        r = '0;
        for (int j = 0; j < P / 2; j++) r[j] = x[2*j] | x[2*j+1];
        return r;
    endfunction

    logic [P-1:0] lvl    [0:D];
    logic [P-1:0] lvl_in [0:D-1];
    logic [P-1:0] stg_q  [0:S-1];

    // Leaves beyond WIDTH are zero so they never contribute to the OR.
    assign lvl[0] = P'(a);

    genvar l, s;
    generate
        for (l = 0; l < D; l++) begin : g_lvl
            if ((l % LPS == 0) && (l != 0)) begin : g_reg_src
                assign lvl_in[l] = stg_q[l/LPS-1];
            end else begin : g_comb_src
                assign lvl_in[l] = lvl[l];
            end
            assign lvl[l+1] = or_level(lvl_in[l]);
        end

        for (s = 0; s < S; s++) begin : g_stg
            localparam int E = ((s + 1) * LPS < D) ? (s + 1) * LPS : D;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)     stg_q[s] <= '0;
                else if (en[s]) stg_q[s] <= lvl[E];
            end
        end
    endgenerate

    assign y = stg_q[S-1][0];
endmodule

module or_tree_pipe #(
    parameter int WIDTH            = 8,
    parameter int LANES            = 4,
    parameter int LEVELS_PER_STAGE = 2
) (
    input  logic                   CLK,
    input  logic                   R,
    input  logic [LANES*WIDTH-1:0] A,
    input  logic                   VALID_IN,
    output logic                   READY_OUT,
    output logic [LANES-1:0]       Y,
    output logic                   VALID_OUT,
    input  logic                   READY_IN
`ifdef OR_TREE_STICKY_EN
    ,
    input  logic                   CLR,
    output logic [LANES-1:0]       STICKY
`endif
);
    localparam int D  = $clog2(WIDTH);
    localparam int SC = (D + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;
    localparam int S  = (SC < 1) ? 1 : SC;

    logic [S-1:0] vld_q;
    logic [S:0]   vld_pipe;
    logic [S:0]   rdy;
    logic [S-1:0] ld_en;

    assign vld_pipe = {vld_q, VALID_IN};

    // Ready ripples back from the output; a stage with a bubble always accepts.
    always_comb begin
        rdy    = '0;
        ld_en  = '0;
        rdy[S] = READY_IN;
        for (int i = S - 1; i >= 0; i--) begin
            rdy[i]   = !vld_q[i] || rdy[i+1];
            ld_en[i] = rdy[i] && vld_pipe[i];
        end
    end

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            vld_q <= '0;
        end else begin
            for (int i = 0; i < S; i++)
                if (rdy[i]) vld_q[i] <= vld_pipe[i];
        end
    end

    assign READY_OUT = rdy[0];
    assign VALID_OUT = vld_q[S-1];

    genvar k;
    generate
        for (k = 0; k < LANES; k++) begin : g_lane
            or_tree_lane #(
                .WIDTH (WIDTH),
                .LPS   (LEVELS_PER_STAGE),
                .D     (D),
                .S     (S)
            ) u_lane (
                .clk   (CLK),
                .rst_n (R),
                .a     (A[k*WIDTH +: WIDTH]),
                .en    (ld_en),
                .y     (Y[k])
            );
        end
    endgenerate

`ifdef OR_TREE_STICKY_EN
    logic xfer;
    assign xfer = VALID_OUT && READY_IN;

    // Clear wins over the old value but still picks up a coincident transfer.
    always_ff @(posedge CLK or negedge R) begin
        if (!R)        STICKY <= '0;
        else if (CLR)  STICKY <= xfer ? Y : '0;
        else if (xfer) STICKY <= STICKY | Y;
    end
`endif
endmodule
